// File: rtl/mmio_slot_arbiter.sv
// rtl/mmio_slot_arbiter.sv - round-robin two-requester arbiter for one MMIO slot with completion watchdog
module mmio_slot_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [7:0]  req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        timeout,
    output logic        busy,
    output logic        chip_select,
    output logic        read,
    output logic        write,
    output logic [3:0]  addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        wr_done,
    input  logic        rd_done,
    input  logic        idle,
    input  logic        slave_error,
    input  logic        decode_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;
    logic        r_owner;
    logic        r_wr;
    logic [3:0]  r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_cnt;
    logic [31:0] r_rdata;
    logic [1:0]  r_resp;
    logic        r_timeout;

    logic        w_grant;
    logic        w_winner;
    logic        w_complete;
    logic        w_fire;
    logic        w_hs;

    // A tie goes to the pointer side; a lone requester wins regardless of the pointer.
    assign w_winner   = (req_valid == 2'b11) ? r_ptr : req_valid[1];
    assign w_grant    = !rst && (r_state == S_IDLE) && (|req_valid) && idle;
    assign w_complete = decode_error | slave_error | (r_wr ? wr_done : rd_done);
    assign w_fire     = (r_state == S_WAIT) && !w_complete && (r_cnt == LP_CNT_LAST);
    assign w_hs       = (r_state == S_RESP) && rsp_ready[r_owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_complete || w_fire) w_next = S_RESP;
            S_RESP:  if (w_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 1'b0;
            r_owner   <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= 4'd0;
            r_wdata   <= 32'd0;
            r_cnt     <= 16'd0;
            r_rdata   <= 32'd0;
            r_resp    <= 2'b00;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_fire;
            if (w_grant) begin
                r_owner <= w_winner;
                r_ptr   <= ~w_winner;
                r_wr    <= req_write[w_winner];
                r_addr  <= w_winner ? req_addr[7:4] : req_addr[3:0];
                r_wdata <= w_winner ? req_wdata[63:32] : req_wdata[31:0];
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
                if (w_complete) begin
                    r_resp  <= decode_error ? 2'b11 : (slave_error ? 2'b10 : 2'b00);
                    r_rdata <= (!decode_error && !slave_error && !r_wr) ? rd_data : 32'd0;
                end else if (w_fire) begin
                    r_resp  <= 2'b10;
                    r_rdata <= 32'd0;
                end
            end
            if (w_hs) begin
                r_cnt   <= 16'd0;
                r_resp  <= 2'b00;
                r_rdata <= 32'd0;
            end
        end
    end

    always_comb begin
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        chip_select = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        addr        = 4'd0;
        wr_data     = 32'd0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_grant) req_ready[w_winner] = 1'b1;
            end
            S_ISSUE: begin
                chip_select = 1'b1;
                read        = !r_wr;
                write       = r_wr;
                addr        = r_addr;
                wr_data     = r_wdata;
            end
            S_WAIT: begin
                chip_select = 1'b1;
                addr        = r_addr;
                wr_data     = r_wdata;
            end
            S_RESP: begin
                rsp_valid[r_owner] = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_mmio_slot_arbiter.sv
// tb/tb_mmio_slot_arbiter.sv - directed self-checking bench for mmio_slot_arbiter
module tb_mmio_slot_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout;
    logic        busy;
    logic        chip_select;
    logic        read;
    logic        write;
    logic [3:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        wr_done;
    logic        rd_done;
    logic        idle;
    logic        slave_error;
    logic        decode_error;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_slot_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout), .busy(busy),
        .chip_select(chip_select), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .wr_done(wr_done), .rd_done(rd_done), .idle(idle),
        .slave_error(slave_error), .decode_error(decode_error)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot(input int who);
        return (who == 0) ? 2'b01 : 2'b10;
    endfunction

    // Grants a lone request from 'who' and leaves the bench in the first WAIT cycle.
    task automatic issue_txn(input int who, input logic wr, input logic [3:0] a, input logic [31:0] d);
        req_write[who]          = wr;
        req_addr[who*4 +: 4]    = a;
        req_wdata[who*32 +: 32] = d;
        req_valid               = onehot(who);
        #1;
        n_checks++;
        if (req_ready !== onehot(who))
            $display("FAIL grant_req%0d: req_ready=%b expected %b", who, req_ready, onehot(who));
        else n_pass++;
        cyc();
        req_valid = 2'b00;
        n_checks++;
        if ({chip_select, read, write, addr, wr_data} !== {1'b1, ~wr, wr, a, d})
            $display("FAIL issue_req%0d: cs=%b rd=%b wr=%b addr=%h wdata=%h expected cs=1 rd=%b wr=%b addr=%h wdata=%h",
                     who, chip_select, read, write, addr, wr_data, ~wr, wr, a, d);
        else n_pass++;
        cyc();
    endtask

    task automatic finish_rsp(input int who);
        rsp_ready = onehot(who);
        cyc();
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        cyc();
        n_checks++;
        if ({req_ready, rsp_valid, busy, chip_select, read, write} !== 8'd0)
            $display("FAIL reset_held: rr=%b rv=%b busy=%b cs=%b rd=%b wr=%b expected all 0",
                     req_ready, rsp_valid, busy, chip_select, read, write);
        else n_pass++;
        rst       = 1'b0;
        req_valid = 2'b00;
        cyc();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_resp, timeout, busy, chip_select, read, write, addr, wr_data} !== '0)
            $display("FAIL reset_outputs: rr=%b rv=%b rdata=%h resp=%b to=%b busy=%b cs=%b addr=%h wdata=%h expected all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_resp, timeout, busy, chip_select, addr, wr_data);
        else n_pass++;
    endtask

    task automatic test_single_read();
        issue_txn(0, 1'b0, 4'h3, 32'h0);
        n_checks++;
        if ({chip_select, read, busy} !== 3'b101)
            $display("FAIL read_wait1: cs=%b rd=%b busy=%b expected cs=1 rd=0 busy=1", chip_select, read, busy);
        else n_pass++;
        cyc();
        rd_done = 1'b1;
        rd_data = 32'hDEADBEEF;
        cyc();
        rd_done = 1'b0;
        rd_data = 32'h0;
        n_checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata, chip_select} !== {2'b01, 2'b00, 32'hDEADBEEF, 1'b0})
            $display("FAIL read_rsp: rv=%b resp=%b rdata=%h cs=%b expected rv=01 resp=00 rdata=deadbeef cs=0",
                     rsp_valid, rsp_resp, rsp_rdata, chip_select);
        else n_pass++;
        finish_rsp(0);
        n_checks++;
        if ({busy, rsp_valid} !== 3'b000)
            $display("FAIL read_done: busy=%b rv=%b expected busy=0 rv=00", busy, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_contention();
        int k0 = 0;
        int k1 = 0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_write = 2'b11;
        req_valid = 2'b11;
        for (int t = 0; t < 8; t++) begin
            int w;
            logic [3:0]  ea;
            logic [31:0] ed;
            w = t % 2;
            req_addr[3:0]    = 4'(k0);
            req_wdata[31:0]  = 32'hA000_0000 | 32'(k0);
            req_addr[7:4]    = 4'(8 + k1);
            req_wdata[63:32] = 32'hA001_0000 | 32'(k1);
            ea = (w == 0) ? 4'(k0) : 4'(8 + k1);
            ed = (w == 0) ? (32'hA000_0000 | 32'(k0)) : (32'hA001_0000 | 32'(k1));
            #1;
            n_checks++;
            if (req_ready !== onehot(w))
                $display("FAIL rr_grant_%0d: req_ready=%b expected %b", t, req_ready, onehot(w));
            else n_pass++;
            cyc();
            if (w == 0) k0++; else k1++;
            n_checks++;
            if ({chip_select, read, write, addr, wr_data} !== {3'b101, ea, ed})
                $display("FAIL rr_issue_%0d: cs=%b rd=%b wr=%b addr=%h wdata=%h expected cs=1 rd=0 wr=1 addr=%h wdata=%h",
                         t, chip_select, read, write, addr, wr_data, ea, ed);
            else n_pass++;
            cyc();
            wr_done = 1'b1;
            cyc();
            wr_done = 1'b0;
            n_checks++;
            if ({rsp_valid, rsp_resp} !== {onehot(w), 2'b00})
                $display("FAIL rr_rsp_%0d: rv=%b resp=%b expected rv=%b resp=00", t, rsp_valid, rsp_resp, onehot(w));
            else n_pass++;
            rsp_ready = 2'b11;
            cyc();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_errors();
        issue_txn(0, 1'b0, 4'h5, 32'h0);
        decode_error = 1'b1; slave_error = 1'b1; rd_done = 1'b1; rd_data = 32'h1234_5678;
        cyc();
        decode_error = 1'b0; slave_error = 1'b0; rd_done = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b01, 2'b11, 32'h0})
            $display("FAIL err_decerr: rv=%b resp=%b rdata=%h expected rv=01 resp=11 rdata=0", rsp_valid, rsp_resp, rsp_rdata);
        else n_pass++;
        finish_rsp(0);

        issue_txn(1, 1'b0, 4'h9, 32'h0);
        slave_error = 1'b1; rd_data = 32'hFFFF_FFFF;
        cyc();
        slave_error = 1'b0; rd_data = 32'h0;
        n_checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b10, 2'b10, 32'h0})
            $display("FAIL err_slverr: rv=%b resp=%b rdata=%h expected rv=10 resp=10 rdata=0", rsp_valid, rsp_resp, rsp_rdata);
        else n_pass++;
        finish_rsp(1);

        issue_txn(0, 1'b1, 4'hC, 32'hCAFE_F00D);
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
        n_checks++;
        if ({chip_select, rsp_valid, busy} !== 4'b1001)
            $display("FAIL err_wrong_done: cs=%b rv=%b busy=%b expected cs=1 rv=00 busy=1", chip_select, rsp_valid, busy);
        else n_pass++;
        wr_done = 1'b1;
        cyc();
        wr_done = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b01, 2'b00, 32'h0})
            $display("FAIL err_write_ok: rv=%b resp=%b rdata=%h expected rv=01 resp=00 rdata=0", rsp_valid, rsp_resp, rsp_rdata);
        else n_pass++;
        finish_rsp(0);
    endtask

    task automatic test_timeout();
        issue_txn(1, 1'b0, 4'h2, 32'h0);
        repeat (7) cyc();
        n_checks++;
        if ({timeout, chip_select, rsp_valid} !== 4'b0100)
            $display("FAIL to_last_wait: to=%b cs=%b rv=%b expected to=0 cs=1 rv=00", timeout, chip_select, rsp_valid);
        else n_pass++;
        cyc();
        n_checks++;
        if ({timeout, chip_select, rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 2'b10, 2'b10, 32'h0})
            $display("FAIL to_fire: to=%b cs=%b rv=%b resp=%b rdata=%h expected to=1 cs=0 rv=10 resp=10 rdata=0",
                     timeout, chip_select, rsp_valid, rsp_resp, rsp_rdata);
        else n_pass++;
        cyc();
        n_checks++;
        if ({timeout, rsp_valid, rsp_resp} !== {1'b0, 2'b10, 2'b10})
            $display("FAIL to_pulse_once: to=%b rv=%b resp=%b expected to=0 rv=10 resp=10", timeout, rsp_valid, rsp_resp);
        else n_pass++;
        finish_rsp(1);
        issue_txn(0, 1'b0, 4'h1, 32'h0);
        rd_done = 1'b1; rd_data = 32'h600D_600D;
        cyc();
        rd_done = 1'b0; rd_data = 32'h0;
        n_checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata, timeout} !== {2'b01, 2'b00, 32'h600D_600D, 1'b0})
            $display("FAIL to_next_txn: rv=%b resp=%b rdata=%h to=%b expected rv=01 resp=00 rdata=600d600d to=0",
                     rsp_valid, rsp_resp, rsp_rdata, timeout);
        else n_pass++;
        finish_rsp(0);
    endtask

    task automatic test_backpressure();
        issue_txn(1, 1'b0, 4'h7, 32'h0);
        rd_done = 1'b1; rd_data = 32'h5A5A_A5A5;
        cyc();
        rd_done = 1'b0; rd_data = 32'h0;
        req_valid = 2'b11;
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({rsp_valid, rsp_resp, rsp_rdata, req_ready} !== {2'b10, 2'b00, 32'h5A5A_A5A5, 2'b00})
                $display("FAIL bp_hold_%0d: rv=%b resp=%b rdata=%h rr=%b expected rv=10 resp=00 rdata=5a5aa5a5 rr=00",
                         i, rsp_valid, rsp_resp, rsp_rdata, req_ready);
            else n_pass++;
            cyc();
        end
        req_valid = 2'b00;
        finish_rsp(1);

        idle          = 1'b0;
        req_write[0]  = 1'b0;
        req_addr[3:0] = 4'h4;
        req_valid     = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({req_ready, busy} !== 3'b000)
                $display("FAIL idle_block_%0d: rr=%b busy=%b expected rr=00 busy=0", i, req_ready, busy);
            else n_pass++;
            cyc();
        end
        idle = 1'b1;
        issue_txn(0, 1'b0, 4'h4, 32'h0);
        rd_done = 1'b1; rd_data = 32'h0000_0044;
        cyc();
        rd_done = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h0000_0044})
            $display("FAIL idle_rsp: rv=%b rdata=%h expected rv=01 rdata=00000044", rsp_valid, rsp_rdata);
        else n_pass++;
        finish_rsp(0);
    endtask

    task automatic test_reset_in_wait();
        issue_txn(0, 1'b1, 4'hB, 32'h1111_2222);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_resp, timeout, busy, chip_select, read, write, addr, wr_data} !== '0)
            $display("FAIL rstwait_outputs: rr=%b rv=%b rdata=%h resp=%b to=%b busy=%b cs=%b addr=%h wdata=%h expected all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_resp, timeout, busy, chip_select, addr, wr_data);
        else n_pass++;
        wr_done = 1'b1;
        cyc();
        wr_done = 1'b0;
        n_checks++;
        if ({rsp_valid, busy} !== 3'b000)
            $display("FAIL rstwait_no_rsp: rv=%b busy=%b expected rv=00 busy=0", rsp_valid, busy);
        else n_pass++;
        req_write        = 2'b11;
        req_addr         = 8'hE6;
        req_wdata        = {32'hBBBB_0001, 32'hAAAA_0000};
        req_valid        = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01)
            $display("FAIL rstwait_ptr: req_ready=%b expected 01", req_ready);
        else n_pass++;
        cyc();
        req_valid = 2'b00;
        n_checks++;
        if ({write, addr, wr_data} !== {1'b1, 4'h6, 32'hAAAA_0000})
            $display("FAIL rstwait_issue: wr=%b addr=%h wdata=%h expected wr=1 addr=6 wdata=aaaa0000", write, addr, wr_data);
        else n_pass++;
        cyc();
        wr_done = 1'b1;
        cyc();
        wr_done = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_resp} !== 4'b0100)
            $display("FAIL rstwait_rsp: rv=%b resp=%b expected rv=01 resp=00", rsp_valid, rsp_resp);
        else n_pass++;
        finish_rsp(0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_addr = 8'h0; req_wdata = 64'h0;
        rsp_ready = 2'b00; rd_data = 32'h0; wr_done = 1'b0; rd_done = 1'b0;
        idle = 1'b1; slave_error = 1'b0; decode_error = 1'b0;
        cyc();
        test_reset();
        test_single_read();
        test_contention();
        test_errors();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_slot_arbiter.md
Name: mmio_slot_arbiter

Overview:
Shares one MMIO peripheral slot (timer-style slot interface: chip_select/read/write/addr/wr_data, with rd_data/wr_done/rd_done/idle/slave_error/decode_error returned) between two requesters, e.g. the AXI MMIO controller and a debug/DMA master. It uses round-robin arbitration and allows one outstanding transaction at a time. It also provides a completion-timeout watchdog and returns a response code to the winning requester. It sits between the requesters and a single slot instance inside the MMIO subsystem.

Parameters:
TIMEOUT_CYCLES, 256, WAIT-state cycles without completion before forcing a timeout response (legal range 2..65535).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester transaction request (bit i = requester i)
req_write  in  2  1 = write, 0 = read
req_addr  in  8  requester i register address at [4i+3:4i]
req_wdata  in  64  requester i write data at [32i+31:32i]
req_ready  out  2  one-cycle grant/accept pulse; payload captured this cycle
rsp_valid  out  2  response valid to requester i
rsp_ready  in  2  requester i accepts response
rsp_rdata  out  32  read data (shared; qualified by rsp_valid)
rsp_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
timeout  out  1  one-cycle pulse when the watchdog fires
busy  out  1  high in any state other than IDLE
chip_select  out  1  slot select
read  out  1  slot read strobe
write  out  1  slot write strobe
addr  out  4  slot register address
wr_data  out  32  slot write data
rd_data  in  32  slot read data
wr_done  in  1  slot write complete
rd_done  in  1  slot read complete
idle  in  1  slot ready for a new access
slave_error  in  1  slot slave error
decode_error  in  1  slot decode error

Behaviour:
- Reset: every output is 0. State is IDLE, the RR pointer is 0 and the timeout counter is 0. Reset mid-transaction drops the transaction with no response; the slot is released the next cycle.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant when any req_valid=1 and idle=1.
  - If both requesters are valid, the pointer side wins; otherwise the sole valid requester wins.
  - req_ready[winner]=1 for one cycle. Capture write, addr and wdata, then go to ISSUE.
  - The pointer moves to the non-winner at grant.
  - If idle=0, no grant is made.
- ISSUE (1 cycle): chip_select=1, plus read or write=1 per the captured op. addr and wr_data are driven from the captured values. Then go to WAIT.
  - Slot status inputs are ignored this cycle.
- WAIT:
  - chip_select=1, read=write=0, addr/wr_data held.
  - The counter increments each cycle.
  - Completion priority: decode_error → 11, else slave_error → 10, else matching done (wr_done for write, rd_done for read) → 00.
  - A non-matching done is ignored.
  - On rd_done with OKAY, capture rd_data into rsp_rdata; otherwise rsp_rdata=0.
  - If the counter reaches TIMEOUT_CYCLES with no completion: resp 10, timeout pulse for 1 cycle, rsp_rdata 0.
  - Any completion or timeout: go to RESP; chip_select drops in the RESP cycle.
- RESP: rsp_valid[winner]=1, with rsp_resp/rsp_rdata stable until rsp_ready[winner]=1. On that handshake, go to IDLE in the next cycle and clear the counter. rsp_ready of the non-winner is ignored.
- Latency (grant at cycle T): strobe at T+1, earliest completion sampled at T+2, rsp_valid from T+3. Best-case back-to-back throughput is one transaction per 4 cycles plus response stall.
- A requester may deassert req_valid before grant with no effect. Payload is captured only at grant.
- Counter width is 16 bits; it never wraps (saturating is irrelevant because timeout fires first).

Test Plan:
- Single read: requester 0 reads addr 3, slot asserts rd_done with rd_data=0xDEADBEEF 2 cycles after strobe → read pulses at T+1, rsp_valid[0] with rsp_rdata 0xDEADBEEF and resp 00.
- Contention: both valid continuously, 4 writes each → grants alternate 0,1,0,1…; each write presents the correct addr/wr_data on the slot.
- Errors: slave asserts decode_error and slave_error together → resp 11. slave_error alone → 10, rsp_rdata 0. rd_done during a write is ignored until wr_done arrives.
- Timeout: TIMEOUT_CYCLES=8, slot never responds → timeout pulses once, resp 10, chip_select low in the RESP cycle, next grant proceeds.
- Backpressure/idle: rsp_ready held low 5 cycles → response held stable and no new grant. idle=0 with req_valid=1 → no req_ready until idle=1.
- Reset in WAIT: assert rst for 1 cycle → all outputs 0 next cycle, no rsp_valid, pointer 0 (requester 0 wins the next tie).
